// File: rtl/vx_commit_gather.sv
// vx_commit_gather: reassembles lane-sliced commit packets (NUM_LANES wide,
// indexed by pid, framed by sop/eop) into one full-warp commit record with
// a registered active-thread count. The record is held in FULL until the
// downstream handshake; a new packet may load in that same cycle.
module vx_commit_gather #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6,
  parameter int PC_BITS     = 30,
  parameter int UUID_WIDTH  = 1,
  parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [PC_BITS-1:0]          in_PC,
  input  logic                        in_wb,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [PC_BITS-1:0]          out_PC,
  output logic                        out_wb,
  output logic [NR_BITS-1:0]          out_rd,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic [$clog2(NUM_THREADS):0] out_count,
  output logic                        err
);
  localparam int NUM_SLICES = NUM_THREADS / NUM_LANES;
  localparam int CNT_W      = $clog2(NUM_THREADS) + 1;

  typedef enum logic [1:0] {IDLE, GATHER, FULL} state_t;
  state_t state_q, state_d;

  logic [NUM_LANES-1:0][XLEN-1:0]   in_d;
  logic [NUM_THREADS-1:0]           tmask_q, tmask_d;
  logic [NUM_THREADS-1:0][XLEN-1:0] data_q, data_d;
  logic [PID_WIDTH-1:0]             exp_pid_q;
  logic [CNT_W-1:0]                 count_q;
  logic                             fire, start, cont, stray, pid_bad, wid_bad, err_d;

  assign in_d = in_data;

  // start: any accepted sop; cont: accepted slice continuing an open record;
  // stray: accepted non-sop with no open record (dropped).
  assign fire    = in_valid && in_ready;
  assign start   = fire && in_sop;
  assign cont    = fire && !in_sop && (state_q == GATHER);
  assign stray   = fire && !in_sop && (state_q != GATHER);
  assign pid_bad = (NUM_SLICES > 1) && (in_pid != exp_pid_q);
  assign wid_bad = (in_wid != out_wid);
  assign err_d   = (start && state_q == GATHER) || stray || (cont && (pid_bad || wid_bad));

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_THREADS-1:0] m);
    popcnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) popcnt += CNT_W'(m[i]);
  endfunction

  // Per-thread slot: a sop clears every slot and fills the addressed slice,
  // a continuation OR-merges the mask bit and overwrites the data word.
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
    localparam int S = t / NUM_LANES;
    localparam int L = t % NUM_LANES;
    logic hit;
    assign hit = (NUM_SLICES == 1) || (in_pid == PID_WIDTH'(S));
    assign tmask_d[t] = start ? (hit & in_tmask[L])
                      : (cont && hit) ? (tmask_q[t] | in_tmask[L]) : tmask_q[t];
    assign data_d[t]  = start ? (hit ? in_d[L] : '0)
                      : (cont && hit) ? in_d[L] : data_q[t];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: a loaded slice decides GATHER/FULL by eop; a drain without a
  // new sop returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (start || cont)                      state_d = in_eop ? FULL : GATHER;
    else if (state_q == FULL && out_ready)  state_d = IDLE;
  end

  // Handshake outputs; in_ready passes out_ready through so FULL can drain
  // and reload in the same cycle.
  always_comb begin
    out_valid = (state_q == FULL);
    in_ready  = (state_q != FULL) || out_ready;
  end

  // Record datapath, header latched at sop, expected pid and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmask_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      exp_pid_q <= '0;
      err       <= 1'b0;
      out_uuid  <= '0;
      out_wid   <= '0;
      out_PC    <= '0;
      out_wb    <= 1'b0;
      out_rd    <= '0;
    end else begin
      tmask_q <= tmask_d;
      data_q  <= data_d;
      count_q <= popcnt(tmask_d);
      err     <= err_d;
      if (start) begin
        out_uuid  <= in_uuid;
        out_wid   <= in_wid;
        out_PC    <= in_PC;
        out_wb    <= in_wb;
        out_rd    <= in_rd;
        exp_pid_q <= in_pid + PID_WIDTH'(1);
      end else if (cont) begin
        exp_pid_q <= exp_pid_q + PID_WIDTH'(1);
      end
    end
  end

  assign out_tmask = tmask_q;
  assign out_data  = data_q;
  assign out_count = count_q;
endmodule

// File: tb/tb_vx_commit_gather.sv
// Bench for vx_commit_gather: directed scenarios plus random packet streams,
// checked against a transaction-level record model and a one-deep result queue.
module tb_vx_commit_gather;
  logic         clk, reset_n;
  logic         in_valid, in_ready, in_wb, in_sop, in_eop, out_valid, out_ready, out_wb, err;
  logic [0:0]   in_uuid, out_uuid, in_pid;
  logic [1:0]   in_wid, out_wid, in_tmask;
  logic [29:0]  in_PC, out_PC;
  logic [5:0]   in_rd, out_rd;
  logic [63:0]  in_data;
  logic [3:0]   out_tmask;
  logic [127:0] out_data;
  logic [2:0]   out_count;

  vx_commit_gather dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_PC(in_PC), .in_wb(in_wb), .in_rd(in_rd),
    .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_PC(out_PC), .out_wb(out_wb), .out_rd(out_rd), .out_tmask(out_tmask),
    .out_data(out_data), .out_count(out_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   tmask;
    logic [127:0] data;
    logic [2:0]   count;
    logic [0:0]   uuid;
    logic [1:0]   wid;
    logic [29:0]  pc;
    logic         wb;
    logic [5:0]   rd;
  } rec_t;

  rec_t   q[$];
  rec_t   cur;
  bit     open;
  bit [0:0] nxt_pid;
  bit     err_exp;
  int     n_tests, n_fail;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model of one accepted packet, straight from the framing rules.
  task automatic model_accept();
    if (in_sop) begin
      if (open) err_exp = 1;
      cur = '{tmask: '0, data: '0, count: '0, uuid: in_uuid, wid: in_wid,
              pc: in_PC, wb: in_wb, rd: in_rd};
      nxt_pid = in_pid + 1'b1;
      open = 1;
    end else if (!open) begin
      err_exp = 1;
      return;
    end else begin
      if (in_pid != nxt_pid || in_wid != cur.wid) err_exp = 1;
      nxt_pid = nxt_pid + 1'b1;
    end
    for (int l = 0; l < 2; l++) begin
      int th = int'(in_pid) * 2 + l;
      cur.tmask[th] = cur.tmask[th] | in_tmask[l];
      cur.data[th*32 +: 32] = in_data[l*32 +: 32];
    end
    if (in_eop) begin
      int c = 0;
      for (int i = 0; i < 4; i++) c += int'(cur.tmask[i]);
      cur.count = 3'(c);
      q.push_back(cur);
      open = 0;
    end
  endtask

  // One clock cycle: entered just after a falling edge, leaves at the next one.
  task automatic cyc(input bit v, input bit sop, input bit eop, input bit [0:0] pid,
                     input bit [1:0] tm, input bit [1:0] wid, input bit [63:0] d,
                     input bit ordy, output bit fired);
    bit rdy;
    in_valid = v; in_sop = sop; in_eop = eop; in_pid = pid; in_tmask = tm;
    in_wid = wid; in_data = d; out_ready = ordy;
    in_uuid = 1'($urandom); in_PC = 30'($urandom); in_wb = 1'($urandom); in_rd = 6'($urandom);
    #1;
    rdy = (q.size() == 0) || ordy;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, rdy);
    chk("err", err, err_exp);
    if (q.size() != 0) begin
      chk("rec_tmask", out_tmask, q[0].tmask);
      chk("rec_data", out_data, q[0].data);
      chk("rec_count", out_count, q[0].count);
      chk("rec_hdr", {out_uuid, out_wid, out_PC, out_wb, out_rd},
                     {q[0].uuid, q[0].wid, q[0].pc, q[0].wb, q[0].rd});
      if (ordy) void'(q.pop_front());
    end
    err_exp = 0;
    fired = v && rdy;
    if (fired) model_accept();
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    bit f;
    cyc(0, 0, 0, 0, 2'b00, 2'd1, 64'd0, ordy, f);
  endtask

  task automatic pkt(input bit sop, input bit eop, input bit [0:0] pid, input bit [1:0] tm,
                     input bit [63:0] d, input bit ordy);
    bit f;
    cyc(1, sop, eop, pid, tm, 2'd1, d, ordy, f);
  endtask

  // Asynchronous reset while the clock is low; its effect is visible at once.
  task automatic async_reset();
    in_valid = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_tmask", out_tmask, 0);
    chk("rst_count", out_count, 0);
    q.delete(); open = 0; err_exp = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit f;
    bit [1:0] gw;
    int g;
    n_tests = 0; n_fail = 0; open = 0; err_exp = 0; nxt_pid = 0;
    reset_n = 0; in_valid = 0; in_sop = 0; in_eop = 0; in_pid = 0; in_tmask = 0;
    in_wid = 0; in_data = 0; in_uuid = 0; in_PC = 0; in_wb = 0; in_rd = 0; out_ready = 0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_tmask", out_tmask, 0);
    chk("reset_data", out_data, 0);
    chk("reset_count", out_count, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1;

    // Two-slice record: mask 11 then 01 -> 0111, count 3.
    pkt(1, 0, 0, 2'b11, {32'hBBBB0001, 32'hAAAA0000}, 1);
    pkt(0, 1, 1, 2'b01, {32'hDDDD0003, 32'hCCCC0002}, 1);
    #1;
    chk("t1_valid", out_valid, 1);
    chk("t1_tmask", out_tmask, 4'b0111);
    chk("t1_data", out_data, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
    chk("t1_count", out_count, 3);
    chk("t1_err", err, 0);
    idle(1);

    // Backpressure: record held 3 cycles while the next sop waits.
    pkt(1, 0, 0, 2'b10, {32'h2, 32'h1}, 0);
    pkt(0, 1, 1, 2'b11, {32'h4, 32'h3}, 0);
    for (int i = 0; i < 3; i++) pkt(1, 1, 0, 2'b11, {32'h6, 32'h5}, 0);
    pkt(1, 1, 0, 2'b11, {32'h6, 32'h5}, 1);
    idle(1);
    idle(1);

    // Single packet sop=eop, mask 10 -> 0010, upper lanes zero.
    pkt(1, 1, 0, 2'b10, {32'h12345678, 32'h9ABCDEF0}, 1);
    #1;
    chk("t3_tmask", out_tmask, 4'b0010);
    chk("t3_count", out_count, 1);
    chk("t3_hi_zero", out_data[127:64], 0);
    idle(1);

    // Stray non-sop in IDLE, then sop followed by a second sop.
    pkt(0, 1, 1, 2'b11, 64'h55, 1);
    #1;
    chk("t4_err", err, 1);
    chk("t4_no_valid", out_valid, 0);
    err_exp = 1;
    pkt(1, 0, 0, 2'b11, {32'h71, 32'h70}, 1);
    pkt(1, 0, 0, 2'b01, {32'h81, 32'h80}, 1);
    pkt(0, 1, 1, 2'b11, {32'h83, 32'h82}, 1);
    idle(1);
    idle(1);

    // Repeated pid 0: err, slice 0 overwritten.
    pkt(1, 0, 0, 2'b01, {32'h91, 32'h90}, 1);
    pkt(0, 1, 0, 2'b10, {32'h93, 32'h92}, 1);
    idle(1);
    idle(1);

    // Reset mid-gather, then a lone eop must only flag an error.
    pkt(1, 0, 0, 2'b11, 64'hA5, 1);
    async_reset();
    pkt(0, 1, 1, 2'b11, 64'h5A, 1);
    idle(1);
    idle(1);

    // Reset while a completed record is being held.
    pkt(1, 1, 0, 2'b11, 64'h77, 0);
    idle(0);
    async_reset();
    idle(1);

    // Random streams, mostly well-formed, with occasional corrupted fields.
    g = 0; gw = 2'($urandom);
    for (int i = 0; i < 400; i++) begin
      bit s, e, v, o;
      bit [0:0] p;
      bit [1:0] w;
      int r;
      r = $urandom_range(0, 9);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      if (r == 0) begin
        s = 1'($urandom); e = 1'($urandom); p = 1'($urandom); w = 2'($urandom);
      end else if (g == 0) begin
        s = 1; p = 0; e = ($urandom_range(0, 3) == 0);
        gw = 2'($urandom); w = gw;
      end else begin
        s = 0; p = 1; e = 1; w = gw;
      end
      cyc(v, s, e, p, 2'($urandom), w, {32'($urandom), 32'($urandom)}, o, f);
      if (f) g = (s && !e) ? 1 : 0;
    end
    for (int i = 0; i < 3; i++) idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
